// File: rtl/mem_pkg.sv
// Shared encodings, FSM states and the request-legality check for mem_access_ctrl.
package mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned OFF_W  = 2;

  localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
  localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
  localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;
  localparam logic [SIZE_W-1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Control fields of the accepted request, held for the whole transaction.
  typedef struct packed {
    logic              write;
    logic [SIZE_W-1:0] size;
    logic              is_unsigned;
    logic [OFF_W-1:0]  off;
  } req_ctl_t;

  // Illegal size or an address not aligned to the access size.
  function automatic logic access_err(input logic [SIZE_W-1:0] size,
                                      input logic [OFF_W-1:0]  off);
    case (size)
      SZ_BYTE: access_err = 1'b0;
      SZ_HALF: access_err = off[0];
      SZ_WORD: access_err = (off != 2'b00);
      default: access_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Byte/half lane handling: store lane merge into a read word, and load extract with extension.
module mem_lane_merge
  import mem_pkg::*;
(
  input  logic [WORD_W-1:0] rd_word,
  input  logic [WORD_W-1:0] wdata,
  input  logic [SIZE_W-1:0] size,
  input  logic [OFF_W-1:0]  off,
  input  logic              is_unsigned,
  output logic [WORD_W-1:0] merge_word_c,
  output logic [WORD_W-1:0] load_data_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Replace the addressed lane of the memory word with the right-aligned store data.
  always_comb begin
    merge_word_c = rd_word;
    case (size)
      SZ_BYTE: merge_word_c[{off, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: merge_word_c[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: merge_word_c = wdata;
    endcase
  end

  // Pull the addressed lane down to bit 0 and sign- or zero-extend it.
  always_comb begin
    byte_lane   = rd_word[{off, 3'b000} +: 8];
    half_lane   = rd_word[{off[1], 4'b0000} +: 16];
    load_data_c = rd_word;
    case (size)
      SZ_BYTE: load_data_c = is_unsigned ? {24'h000000, byte_lane}
                                         : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data_c = is_unsigned ? {16'h0000, half_lane}
                                         : {{16{half_lane[15]}}, half_lane};
      default: load_data_c = rd_word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the word-only memory_block: one request at a time,
// sub-word loads extracted here, sub-word stores done as read-modify-write.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t      state;
  state_t      state_nxt;
  req_ctl_t    ctl;
  logic        accept_c;
  logic [DATA_W-1:0] merge_word_c;
  logic [DATA_W-1:0] load_data_c;

  assign accept_c = (state == ST_IDLE) && req_valid;

  // Lane logic; the store data is parked in mem_write_data until the merge.
  mem_lane_merge u_lane (
    .rd_word      (mem_read_data),
    .wdata        (mem_write_data),
    .size         (ctl.size),
    .off          (ctl.off),
    .is_unsigned  (ctl.is_unsigned),
    .merge_word_c (merge_word_c),
    .load_data_c  (load_data_c)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: errors skip memory, loads and sub-word stores read first.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (access_err(req_size, req_addr[1:0]))        state_nxt = ST_RESP;
          else if (req_write && (req_size == SZ_WORD))    state_nxt = ST_WR;
          else                                            state_nxt = ST_RD;
        end
      end
      ST_RD:   state_nxt = ctl.write ? ST_WR : ST_RESP;
      ST_WR:   state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and memory strobes decoded from the state register only.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      ST_IDLE: req_ready  = 1'b1;
      ST_RD:   mem_read   = 1'b1;
      ST_WR:   mem_write  = 1'b1;
      ST_RESP: resp_valid = 1'b1;
      default: req_ready  = 1'b0;
    endcase
  end

  // Request capture, read-data capture and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl            <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
    end else if (accept_c) begin
      ctl.write       <= req_write;
      ctl.size        <= req_size;
      ctl.is_unsigned <= req_unsigned;
      ctl.off         <= req_addr[1:0];
      mem_address     <= req_addr[ADDR_W+1:2];
      mem_write_data  <= req_wdata;
      resp_rdata      <= '0;
      resp_err        <= access_err(req_size, req_addr[1:0]);
    end else if (state == ST_RD) begin
      if (ctl.write) mem_write_data <= merge_word_c;
      else           resp_rdata     <= load_data_c;
    end else if ((state == ST_RESP) && resp_ready) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed + random bench for mem_access_ctrl with a behavioural word memory behind it.
module tb_mem_access_ctrl;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned NWORDS = 1 << ADDR_W;

  logic              clk;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_read_data;

  logic [31:0] mem [0:NWORDS-1];
  logic [31:0] ref_mem [int];

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [ADDR_W-1:0] exp_addr = '0;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory_block stand-in: combinational read, write on rising edge.
  assign mem_read_data = mem[mem_address];
  always @(posedge clk) if (mem_write) mem[mem_address] <= mem_write_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count strobes, check exclusivity and address for every memory cycle.
  always @(negedge clk) begin
    if (reset_n && (mem_read || mem_write)) begin
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      check("rd_wr_exclusive", 32'(mem_read && mem_write), 32'd0);
      check("mem_address", 32'(mem_address), 32'(exp_addr));
    end
  end

  function automatic logic [31:0] ref_rd(input int wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : 32'h0;
  endfunction

  // One full transaction against the reference model, optional RESP hold and poke.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [ADDR_W+1:0] a, input logic [31:0] d,
                        input int hold, input bit poke);
    int          wa, sh, lat, exp_lat, exp_rdc, exp_wrc, rdc0, wrc0;
    logic [31:0] word, mask, exp_rd;
    bit          err, neg;
    wa   = int'(a >> 2);
    word = ref_rd(wa);
    err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    sh   = (sz == 2'd1) ? 16 * int'(a[1]) : (sz == 2'd0) ? 8 * int'(a[1:0]) : 0;
    exp_rd = 32'h0;
    if (err) begin
      exp_lat = 1; exp_rdc = 0; exp_wrc = 0;
    end else if (!w) begin
      exp_rd = (word >> sh) & mask;
      neg    = (sz == 2'd0) ? exp_rd[7] : exp_rd[15];
      if (sz != 2'd2 && !uns && neg) exp_rd = exp_rd | ~mask;
      exp_lat = 2; exp_rdc = 1; exp_wrc = 0;
    end else begin
      ref_mem[wa] = (word & ~(mask << sh)) | ((d & mask) << sh);
      exp_lat = (sz == 2'd2) ? 2 : 3;
      exp_rdc = (sz == 2'd2) ? 0 : 1;
      exp_wrc = 1;
    end

    check("req_ready_idle", 32'(req_ready), 32'd1);
    exp_addr = a[ADDR_W+1:2];
    rd_cnt = 0; wr_cnt = 0;
    req_write = w; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom; req_addr = ADDR_W'($urandom);
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_err", 32'(resp_err), 32'(err));
    check("rd_count", 32'(rd_cnt), 32'(exp_rdc));
    check("wr_count", 32'(wr_cnt), 32'(exp_wrc));
    if (w && !err) check("mem_word", mem[wa], ref_mem[wa]);

    rdc0 = rd_cnt; wrc0 = wr_cnt;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        req_valid = 1'b1; req_write = $urandom; req_size = 2'($urandom);
        req_addr = ADDR_W'($urandom);
      end
      @(posedge clk); #1;
      check("hold_resp_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, exp_rd);
      check("hold_err", 32'(resp_err), 32'(err));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("resp_drop", 32'(resp_valid), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
    check("no_extra_mem", 32'(rd_cnt + wr_cnt), 32'(rdc0 + wrc0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ADDR_W-1:0] wa;
    for (int i = 0; i < int'(NWORDS); i++) mem[i] = 32'h0;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'h0; resp_ready = 1'b0;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_mem_strobes", 32'({mem_read, mem_write}), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Word store/load round trip.
    do_req(1'b1, 2'd2, 1'b0, 20'h00038, 32'd27, 0, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 20'h00038, 32'h0, 0, 1'b0);
    // Byte read-modify-write.
    do_req(1'b1, 2'd2, 1'b0, 20'h00040, 32'h11223344, 0, 1'b0);
    do_req(1'b1, 2'd0, 1'b0, 20'h00041, 32'hDEADBEAA, 0, 1'b0);
    check("rmw_word", mem[16], 32'h1122AA44);
    // Sub-word loads.
    do_req(1'b0, 2'd0, 1'b0, 20'h00041, 32'h0, 0, 1'b0);
    do_req(1'b0, 2'd0, 1'b1, 20'h00041, 32'h0, 0, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 20'h00042, 32'h0, 0, 1'b0);
    // Errors.
    do_req(1'b0, 2'd1, 1'b0, 20'h00043, 32'h0, 0, 1'b0);
    do_req(1'b1, 2'd3, 1'b0, 20'h00040, 32'h12345678, 0, 1'b0);
    // Backpressure with ignored requests.
    do_req(1'b0, 2'd2, 1'b0, 20'h00040, 32'h0, 5, 1'b1);
    // Top word.
    do_req(1'b1, 2'd1, 1'b0, 20'hFFFFE, 32'h0000BEEF, 0, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 20'hFFFFE, 32'h0, 0, 1'b0);

    // Reset during the read phase of a sub-word store.
    do_req(1'b1, 2'd2, 1'b0, 20'h00044, 32'h55667788, 0, 1'b0);
    exp_addr = 18'h00011;
    rd_cnt = 0; wr_cnt = 0;
    req_write = 1'b1; req_size = 2'd0; req_addr = 20'h00045; req_wdata = 32'h99;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_in_rd", 32'(mem_read), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_strobes", 32'({mem_read, mem_write}), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_mem_address", 32'(mem_address), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_write", 32'(wr_cnt), 32'd0);
    check("abort_word", mem[17], ref_rd(17));

    // Random traffic over a small set of words plus the top word.
    for (int n = 0; n < 80; n++) begin
      wa = ($urandom_range(0, 7) == 0) ? 18'h3FFFF : 18'(16 + $urandom_range(0, 7));
      do_req(1'($urandom), 2'($urandom), 1'($urandom), {wa, 2'($urandom)},
             $urandom, int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
